// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
// Imported by the datapath and control modules.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mult_state_t;

   localparam int MULT_WIDTH_DEFAULT = 8;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/add_sub_n.sv
// N-bit ripple-carry adder/subtractor built from full_adder cells.
// sub=1 computes a + ~b + 1; the carry out of the top bit is discarded.
module add_sub_n
   import mult_pkg::*;
#(
   parameter int N = MULT_WIDTH_DEFAULT + 1
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] s
);

   logic [N-1:0] w_bx;
   logic [N-1:0] w_c;

   assign w_bx   = b ^ {N{sub}};
   assign w_c[0] = sub;

   genvar gi;
   for (gi = 0; gi < N - 1; gi++) begin : g_fa
      full_adder u_fa (
         .i_a    (a[gi]),
         .i_b    (w_bx[gi]),
         .i_cin  (w_c[gi]),
         .o_s    (s[gi]),
         .o_cout (w_c[gi+1])
      );
   end

   // Top slice only needs the sum; its carry out would be dropped anyway.
   assign s[N-1] = a[N-1] ^ w_bx[N-1] ^ w_c[N-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build ripple-carry chains.
// Purely combinational.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   logic w_p;

   assign w_p    = i_a ^ i_b;
   assign o_s    = w_p ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential signed shift-and-add multiplier, one multiplier bit per clock.
// Product {A,B} is registered on the last RUN edge and held afterwards.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = cnt_width(WIDTH);

   mult_state_t        r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_s;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [2*WIDTH-1:0] r_product;

   logic [WIDTH:0]     w_aext;
   logic [WIDTH:0]     w_sext;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_t;
   logic               w_last;

   assign w_aext = {r_a[WIDTH-1], r_a};
   assign w_sext = {r_s[WIDTH-1], r_s};
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // The multiplier sign bit carries negative weight, so subtract on the last step.
   add_sub_n #(
      .N (WIDTH + 1)
   ) u_add_sub (
      .a   (w_aext),
      .b   (w_sext),
      .sub (w_last),
      .s   (w_sum)
   );

   assign w_t = r_b[0] ? w_sum : w_aext;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_s       <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_s     <= multiplicand;
                  r_b     <= multiplier;
                  r_a     <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a   <= w_t[WIDTH:1];
               r_b   <= {w_t[0], r_b[WIDTH-1:1]};
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_product <= {w_t, r_b[WIDTH-1:1]};
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed corners plus random ops.
// Expected products come from plain signed integer multiplication.
module tb_shift_add_multiplier;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int checks;
   int errors;
   logic [2*W-1:0] exp_q[$];

   shift_add_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] model(input logic [W-1:0] s,
                                            input logic [W-1:0] m);
      int a;
      int b;
      a = $signed(s);
      b = $signed(m);
      return (2*W)'(a * b);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: product %h, no request pending",
                     product);
         end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            if (product !== e) begin
               errors++;
               $display("FAIL product: got %h, expected %h", product, e);
            end
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_done: got %b, expected 1", busy);
         end
      end
   end

   task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] m,
                        input string name);
      int lat;
      multiplicand = s;
      multiplier   = m;
      start        = 1'b1;
      exp_q.push_back(model(s, m));
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      chk({name, "_latency"}, lat, W + 1);
      @(negedge clk);
      chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int lat;
      logic saw;
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_product", {16'd0, product}, 32'd0);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) saw = 1'b1;
      end
      chk("idle_quiet", {31'd0, saw}, 32'd0);

      do_op(8'd7, 8'hFD, "s7_m-3");
      chk("hold_after_done", {16'd0, product}, 32'h0000FFEB);
      do_op(8'h80, 8'h80, "min_min");
      do_op(8'd127, 8'd127, "max_max");
      do_op(8'd127, 8'h80, "max_min");
      do_op(8'd0, 8'hFF, "zero_neg1");
      do_op(8'hFF, 8'd1, "neg1_one");

      // Start pulse during RUN must be ignored.
      multiplicand = 8'd7;
      multiplier   = 8'hFD;
      start        = 1'b1;
      exp_q.push_back(model(8'd7, 8'hFD));
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 4) begin
            multiplicand = 8'd55;
            multiplier   = 8'd66;
            start        = 1'b1;
         end
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      chk("ignored_start_latency", lat, W + 1);
      repeat (15) @(negedge clk);
      chk("ignored_start_idle", {31'd0, busy}, 32'd0);

      // Start held high: back-to-back ops, one result per W+2 cycles.
      multiplicand = 8'd13;
      multiplier   = 8'hF0;
      start        = 1'b1;
      exp_q.push_back(model(8'd13, 8'hF0));
      exp_q.push_back(model(8'h9C, 8'd21));
      for (int k = 1; k <= 2 * W + 6; k++) begin
         @(negedge clk);
         if (k == 1) begin
            multiplicand = 8'h9C;
            multiplier   = 8'd21;
         end
         if (k == W + 3) start = 1'b0;
         if (k == W + 1) chk("held_done1", {31'd0, done}, 32'd1);
         if (k == W + 2) chk("held_gap_busy", {31'd0, busy}, 32'd0);
         if (k == 2 * W + 3) chk("held_done2", {31'd0, done}, 32'd1);
      end

      // Synchronous reset mid-run aborts with no done pulse.
      multiplicand = 8'd100;
      multiplier   = 8'd99;
      start        = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_product", {16'd0, product}, 32'd0);
      repeat (15) @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         do_op(W'($urandom), W'($urandom), "random");
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
